// File: rtl/code_signal_gen_pkg.sv
// ---------------------------------------------------------------------------
// code_signal_gen_pkg
//   Shared rotate-subsystem definitions for the code-disc emulator:
//   - state_e       : FSM state encoding (IDLE / RUN / STOP_PEND)
//   - PITCH_MIN     : smallest slot pitch (in clocks) the emulator will run
//   - def_pitch()   : default slot pitch derived from the clock period,
//                     motor speed and slots per revolution
// ---------------------------------------------------------------------------
package code_signal_gen_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_RUN       = 2'd1,
        ST_STOP_PEND = 2'd2
    } state_e;

    // Below four clocks the high and low phases of a slot collapse to one
    // or zero clocks, which the receive chain cannot resolve.
    localparam int PITCH_MIN = 4;

    // Clocks per slot at the nominal motor speed:
    // ns per second / ns per clock / revolutions per second / slots per rev.
    function automatic int def_pitch(input int sec2ns_refval,
                                     input int clk_period_ns,
                                     input int motor_freq,
                                     input int tooth_num);
        return sec2ns_refval / clk_period_ns / motor_freq / tooth_num;
    endfunction

endpackage

// File: rtl/code_signal_gen_if.sv
// ---------------------------------------------------------------------------
// code_signal_gen_if
//   Control and output bundle of the code-disc emulator.
//   Ports of the bundle:
//     i_en           run request, level-sensitive
//     i_pitch_clks   slot pitch in clocks (0 selects the default pitch)
//     o_code_sigout  emulated code-disc signal
//     o_tooth_idx    current slot index
//     o_rev_start    one-cycle pulse at the start of slot 0
//     o_busy         high while a revolution is being generated
//   Modports:
//     master : the side that requests runs and observes the code signal
//     slave  : the emulator itself
// ---------------------------------------------------------------------------
interface code_signal_gen_if #(
    parameter int PITCH_W = 20
);

    logic               i_en;
    logic [PITCH_W-1:0] i_pitch_clks;
    logic               o_code_sigout;
    logic [6:0]         o_tooth_idx;
    logic               o_rev_start;
    logic               o_busy;

    modport master (
        output i_en,
        output i_pitch_clks,
        input  o_code_sigout,
        input  o_tooth_idx,
        input  o_rev_start,
        input  o_busy
    );

    modport slave (
        input  i_en,
        input  i_pitch_clks,
        output o_code_sigout,
        output o_tooth_idx,
        output o_rev_start,
        output o_busy
    );

endinterface

// File: rtl/code_signal_gen_timer.sv
// ---------------------------------------------------------------------------
// code_pitch_timer
//   Slot pitch counter of the code-disc emulator. Holds the latched pitch P
//   and the in-slot counter cnt (0..P-1).
//   Ports:
//     i_clk         system clock
//     i_rst         synchronous active-high reset (cnt = 0, P = DEF_PITCH)
//     i_load        latch P from i_pitch_clks (clamped) and restart cnt at 0
//     i_count       advance cnt, wrapping to 0 after P-1
//     i_pitch_clks  requested pitch in clocks
//     o_wrap        cnt is at P-1 (the next counted edge ends the slot)
//     o_high_nxt    the high-phase compare evaluated on the values cnt and P
//                   will hold after the next edge, so the owner can register
//                   the code signal in step with cnt
// ---------------------------------------------------------------------------
module code_pitch_timer
    import code_signal_gen_pkg::*;
#(
    parameter int PITCH_W   = 20,
    parameter int DEF_PITCH = 1000
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_load,
    input  logic               i_count,
    input  logic [PITCH_W-1:0] i_pitch_clks,
    output logic               o_wrap,
    output logic               o_high_nxt
);

    localparam logic [PITCH_W-1:0] DEF_P  = PITCH_W'(DEF_PITCH);
    localparam logic [PITCH_W-1:0] MIN_P  = PITCH_W'(PITCH_MIN);
    localparam logic [PITCH_W-1:0] ZERO_P = {PITCH_W{1'b0}};
    localparam logic [PITCH_W-1:0] ONE_P  = {{(PITCH_W-1){1'b0}}, 1'b1};

    // Pitch latch rule: 0 picks the default, short pitches are raised to
    // the minimum, anything else is used as given.
    function automatic logic [PITCH_W-1:0] clamp_pitch(input logic [PITCH_W-1:0] v);
        logic [PITCH_W-1:0] r;
        if (v == ZERO_P) begin
            r = DEF_P;
        end else if (v < MIN_P) begin
            r = MIN_P;
        end else begin
            r = v;
        end
        return r;
    endfunction

    logic [PITCH_W-1:0] cnt_r;
    logic [PITCH_W-1:0] p_r;
    logic [PITCH_W-1:0] cnt_nxt_s;
    logic [PITCH_W-1:0] p_nxt_s;

    // P never drops below PITCH_MIN, so P-1 cannot underflow, and cnt never
    // needs to reach P itself, so the compare is safe at the full width.
    assign o_wrap = (cnt_r == (p_r - ONE_P));

    // Next counter and pitch values: load wins over count, otherwise hold.
    always_comb begin
        cnt_nxt_s = cnt_r;
        p_nxt_s   = p_r;
        if (i_load) begin
            cnt_nxt_s = ZERO_P;
            p_nxt_s   = clamp_pitch(i_pitch_clks);
        end else if (i_count) begin
            cnt_nxt_s = o_wrap ? ZERO_P : (cnt_r + ONE_P);
            p_nxt_s   = p_r;
        end else begin
            cnt_nxt_s = cnt_r;
            p_nxt_s   = p_r;
        end
    end

    // High phase is the first floor(P/2) clocks of the slot; for odd P the
    // extra clock goes to the low phase.
    assign o_high_nxt = (cnt_nxt_s < (p_nxt_s >> 1));

    // Counter and latched pitch registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt_r <= ZERO_P;
            p_r   <= DEF_P;
        end else begin
            cnt_r <= cnt_nxt_s;
            p_r   <= p_nxt_s;
        end
    end

endmodule

// File: rtl/code_signal_gen.sv
// ---------------------------------------------------------------------------
// code_signal_gen
//   Transmit-side emulator of the optical code disc. Produces TOOTH_NUM
//   equal-pitch slots per revolution on a single code line; slot 0 is the
//   missing tooth and stays low, forming the zero mark for the receiver.
//   Ports:
//     i_clk   system clock
//     i_rst   synchronous active-high reset, forces all outputs low
//     bus     code_signal_gen_if.slave:
//               i_en, i_pitch_clks in; o_code_sigout, o_tooth_idx,
//               o_rev_start, o_busy out (all outputs registered)
//   Run control: i_en high starts a revolution train; i_en low lets the
//   current revolution finish before returning to IDLE. The pitch is only
//   re-latched at revolution boundaries so every revolution is uniform.
// ---------------------------------------------------------------------------
module code_signal_gen
    import code_signal_gen_pkg::*;
#(
    parameter int SEC2NS_REFVAL = 1000_000_000,
    parameter int CLK_PERIOD_NS = 10,
    parameter int MOTOR_FREQ    = 100,
    parameter int TOOTH_NUM     = 100,
    parameter int PITCH_W       = 20,
    parameter int PITCH_MIN_CLK = PITCH_MIN
) (
    input  logic               i_clk,
    input  logic               i_rst,
    code_signal_gen_if.slave   bus
);

    localparam int         DEF_PITCH = def_pitch(SEC2NS_REFVAL, CLK_PERIOD_NS,
                                                 MOTOR_FREQ, TOOTH_NUM);
    localparam logic [6:0] LAST_IDX  = 7'(TOOTH_NUM - 1);
    localparam logic [6:0] ZERO_IDX  = 7'd0;
    localparam logic [6:0] ONE_IDX   = 7'd1;

    state_e     state_r;
    state_e     state_nxt_s;

    logic [6:0] idx_r;
    logic       code_r;
    logic       rev_start_r;
    logic       busy_r;

    logic [6:0] idx_nxt_s;
    logic       code_nxt_s;
    logic       rev_start_nxt_s;
    logic       busy_nxt_s;

    logic       active_s;
    logic       rev_end_s;
    logic       start_s;
    logic       rewrap_s;
    logic       load_s;
    logic       count_s;
    logic       wrap_s;
    logic       high_nxt_s;

    code_pitch_timer #(
        .PITCH_W   (PITCH_W),
        .DEF_PITCH (DEF_PITCH)
    ) u_timer (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_load       (load_s),
        .i_count      (count_s),
        .i_pitch_clks (bus.i_pitch_clks),
        .o_wrap       (wrap_s),
        .o_high_nxt   (high_nxt_s)
    );

    assign active_s  = (state_r == ST_RUN) || (state_r == ST_STOP_PEND);
    // Last clock of the last slot: the next counted edge starts slot 0.
    assign rev_end_s = wrap_s && (idx_r == LAST_IDX);

    // FSM state register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state: a stop request only takes effect at the revolution
    // boundary, and i_en returning in time cancels it.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                state_nxt_s = bus.i_en ? ST_RUN : ST_IDLE;
            end
            ST_RUN: begin
                state_nxt_s = bus.i_en ? ST_RUN : ST_STOP_PEND;
            end
            ST_STOP_PEND: begin
                if (bus.i_en) begin
                    state_nxt_s = ST_RUN;
                end else if (rev_end_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_STOP_PEND;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Timer control. A new revolution (from IDLE, or a boundary that does
    // not end in IDLE) re-latches P; the counter runs whenever active,
    // including the final edge that returns to IDLE so cnt lands on 0.
    always_comb begin
        start_s  = (state_r == ST_IDLE) && bus.i_en;
        rewrap_s = active_s && rev_end_s && (state_nxt_s != ST_IDLE);
        load_s   = start_s || rewrap_s;
        count_s  = active_s;
    end

    // FSM outputs: next values of the registered outputs, computed from
    // the same next cnt/P/idx so the code line stays aligned with them.
    always_comb begin
        idx_nxt_s       = idx_r;
        rev_start_nxt_s = start_s || rewrap_s;
        busy_nxt_s      = (state_nxt_s != ST_IDLE);
        if (!active_s) begin
            idx_nxt_s = ZERO_IDX;
        end else if (wrap_s) begin
            idx_nxt_s = rev_end_s ? ZERO_IDX : (idx_r + ONE_IDX);
        end else begin
            idx_nxt_s = idx_r;
        end
        // Slot 0 is the missing tooth and never goes high.
        code_nxt_s = busy_nxt_s && (idx_nxt_s != ZERO_IDX) && high_nxt_s;
    end

    // Output registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            idx_r       <= ZERO_IDX;
            code_r      <= 1'b0;
            rev_start_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            idx_r       <= idx_nxt_s;
            code_r      <= code_nxt_s;
            rev_start_r <= rev_start_nxt_s;
            busy_r      <= busy_nxt_s;
        end
    end

    assign bus.o_code_sigout = code_r;
    assign bus.o_tooth_idx   = idx_r;
    assign bus.o_rev_start   = rev_start_r;
    assign bus.o_busy        = busy_r;

    // The minimum pitch is fixed by the package; this parameter only exists
    // so integrators can see it at the instance.
    logic unused_min_s;
    assign unused_min_s = (PITCH_MIN_CLK == PITCH_MIN) ? 1'b0 : 1'b1;

endmodule

// File: tb/tb_code_signal_gen.sv
// ---------------------------------------------------------------------------
// tb_code_signal_gen
//   Scoreboarded bench for code_signal_gen. The DUT runs with a short
//   revolution (12 slots, default pitch 83 clocks) so several full
//   revolutions fit in the run. The reference describes the disc as a single
//   position within the revolution; slot index and in-slot phase are derived
//   from it by division.
// ---------------------------------------------------------------------------
module tb_code_signal_gen;

    localparam int N   = 12;
    localparam int MF  = 100000;
    localparam int DEF = 1000000000 / 10 / MF / N;   // 83

    typedef struct packed {
        logic       code;
        logic [6:0] idx;
        logic       rev;
        logic       busy;
    } exp_t;

    logic clk;
    logic rst;

    code_signal_gen_if #(.PITCH_W(20)) bus ();

    code_signal_gen #(
        .MOTOR_FREQ (MF),
        .TOOTH_NUM  (N)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference: running flag, pending-stop flag, latched pitch, position.
    bit m_run  = 1'b0;
    bit m_stop = 1'b0;
    int m_p    = DEF;
    int m_pos  = 0;

    function automatic int clamp(input int v);
        if (v == 0) return DEF;
        if (v < 4)  return 4;
        return v;
    endfunction

    // Drive one cycle of inputs and predict the outputs after the next edge.
    task automatic step(input bit en, input int pitch, input bit r);
        exp_t e;
        bit   rev;
        int   idx;
        @(negedge clk);
        bus.i_en         = en;
        bus.i_pitch_clks = 20'(pitch);
        rst              = r;
        rev              = 1'b0;
        if (r) begin
            m_run = 1'b0; m_stop = 1'b0; m_pos = 0; m_p = DEF;
        end else if (!m_run) begin
            if (en) begin
                m_run = 1'b1; m_stop = 1'b0; m_p = clamp(pitch); m_pos = 0; rev = 1'b1;
            end
        end else begin
            if (m_pos == N * m_p - 1) begin
                if (m_stop && !en) begin
                    m_run = 1'b0; m_pos = 0;
                end else begin
                    m_pos = 0; m_p = clamp(pitch); rev = 1'b1;
                end
            end else begin
                m_pos++;
            end
            m_stop = !en;
        end
        idx    = m_run ? (m_pos / m_p) : 0;
        e.code = m_run && (idx != 0) && ((m_pos % m_p) < (m_p / 2));
        e.idx  = 7'(idx);
        e.rev  = rev;
        e.busy = m_run;
        exp_q.push_back(e);
    endtask

    task automatic run_n(input int n, input bit en, input int pitch);
        for (int k = 0; k < n; k++) step(en, pitch, 1'b0);
    endtask

    // Advance (by the reference's own position) until slot s is reached.
    task automatic run_until_slot(input int s, input bit en, input int pitch);
        for (int k = 0; k < 20000; k++) begin
            if (m_run && (m_pos / m_p) == s) break;
            step(en, pitch, 1'b0);
        end
    endtask

    // Monitor: every cycle the DUT presents a new output sample.
    exp_t mon_e;
    exp_t mon_got;
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            mon_e   = exp_q.pop_front();
            mon_got = {bus.o_code_sigout, bus.o_tooth_idx, bus.o_rev_start, bus.o_busy};
            n_cmp++;
            if (mon_got !== mon_e) begin
                n_bad++;
                $display("FAIL outputs t=%0t got code=%0b idx=%0d rev=%0b busy=%0b exp code=%0b idx=%0d rev=%0b busy=%0b",
                         $time, mon_got.code, mon_got.idx, mon_got.rev, mon_got.busy,
                         mon_e.code, mon_e.idx, mon_e.rev, mon_e.busy);
            end
        end
    end

    initial begin
        bit cur_en;
        int cur_pitch;
        rst              = 1'b1;
        bus.i_en         = 1'b0;
        bus.i_pitch_clks = 20'd0;

        // Reset, then idle.
        for (int k = 0; k < 3; k++) step(1'b0, 0, 1'b1);
        run_n(5, 1'b0, 0);

        // Default pitch, two full revolutions.
        run_n(2 * N * DEF + 50, 1'b1, 0);

        // Pitch change mid-revolution takes effect at the next slot 0.
        run_until_slot(5, 1'b1, 0);
        run_n(N * DEF, 1'b1, 20);
        run_n(N * 20 * 2, 1'b1, 20);

        // Clamping to the minimum pitch, then an odd pitch.
        run_n(N * 20 + N * 4 * 2, 1'b1, 1);
        run_n(N * 4 * 2 + 10, 1'b1, 3);
        run_n(N * 4 + N * 7 * 2, 1'b1, 7);

        // Stop request: revolution finishes, then IDLE without a pulse.
        run_until_slot(4, 1'b1, 7);
        run_n(N * 7 + 20, 1'b0, 7);

        // Restart, drop at slot 4, reassert at slot 8: no stop.
        run_until_slot(4, 1'b1, 7);
        run_until_slot(8, 1'b0, 7);
        run_n(N * 7 * 2, 1'b1, 7);

        // Reset inside the high phase of slot 5, then restart.
        run_until_slot(5, 1'b1, 7);
        run_n(1, 1'b1, 7);
        step(1'b1, 7, 1'b1);
        run_n(3, 1'b0, 7);
        run_n(N * 7 + 20, 1'b1, 7);

        // Randomised run-request, pitch and reset activity.
        cur_en    = 1'b1;
        cur_pitch = 5;
        for (int k = 0; k < 4000; k++) begin
            if ($urandom_range(0, 199) == 0) cur_en = !cur_en;
            if ($urandom_range(0, 99) == 0)  cur_pitch = int'($urandom_range(0, 24));
            step(cur_en, cur_pitch, ($urandom_range(0, 1499) == 0));
        end

        // Drain the scoreboard.
        @(posedge clk);
        #2;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain got %0d pending exp 0 pending", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
